// File: rtl/rotate_left_seq_if.sv
// Operand/result bundle for the sequential left rotator/shifter.
// The master side issues requests and the slave side (the rotator) returns results.
interface rotate_left_seq_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             start;
  logic [WIDTH-1:0] In;
  logic [SHW-1:0]   ShAmt;
  logic             Op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Out;

  modport master (output start, In, ShAmt, Op, input  busy, done, Out);
  modport slave  (input  start, In, ShAmt, Op, output busy, done, Out);
endinterface

// File: rtl/rotate_left_seq.sv
// Multi-cycle left rotator / logical left shifter. It moves one bit per clock.
// A start/done handshake is used, and a new request is accepted in the done cycle.
module rotate_left_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  rotate_left_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   count;
  logic             op_r;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Op=1 zero-fills the LSB. Op=0 wraps the MSB around.
  assign shifted = op_r ? {data[WIDTH-2:0], 1'b0}
                        : {data[WIDTH-2:0], data[WIDTH-1]};

  assign accept = bus.start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start)           state_nxt = (bus.ShAmt != '0) ? SHIFT : DONE;
        else if (state == DONE)  state_nxt = IDLE;
      end
      SHIFT: begin
        if (count == SHW'(1))    state_nxt = DONE;
      end
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
      op_r  <= 1'b0;
      out_q <= '0;
    end else if (accept) begin
      data  <= bus.In;
      count <= bus.ShAmt;
      op_r  <= bus.Op;
      if (bus.ShAmt == '0) out_q <= bus.In;
    end else if (state == SHIFT) begin
      data  <= shifted;
      count <= count - SHW'(1);
      if (count == SHW'(1)) out_q <= shifted;
    end
  end

  // Outputs decode registered state only, so inputs have no combinational path to them.
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.Out  = out_q;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Randomised and directed bench for rotate_left_seq.
// Results are compared against an arithmetic rotate/shift model.
module tb_rotate_left_seq;
  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] last_out = '0;

  rotate_left_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  rotate_left_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] x, input int n, input bit op);
    logic [31:0] w;
    w = {16'h0, x};
    if (op) return 16'((w << n) & 32'h0000_FFFF);
    return 16'(((w << n) | (w >> (16 - n))) & 32'h0000_FFFF);
  endfunction

  // Call at a negedge. The request is driven for exactly one rising edge, and the task returns at the following negedge.
  task automatic launch(input logic [15:0] x, input int n, input bit op);
    bus.start = 1'b1;
    bus.In    = x;
    bus.ShAmt = SHW'(n);
    bus.Op    = op;
    @(negedge clk);
    bus.start = 1'b0;
    bus.In    = 16'(x ^ 16'h5A5A);
    bus.ShAmt = SHW'(n + 3);
    bus.Op    = ~op;
  endtask

  // Latency is counted in negedges since the accept edge. The first negedge counts as 1, and a timeout returns -1.
  task automatic wait_done(input logic [15:0] prev_out, output int lat, output int busy_cyc,
                           output int overlap, output int out_moved);
    bit found;
    found = 0; lat = -1; busy_cyc = 0; overlap = 0; out_moved = 0;
    for (int n = 1; n <= 40 && !found; n++) begin
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        lat = n;
        found = 1;
      end else begin
        if (bus.busy) busy_cyc++;
        if (bus.Out !== prev_out) out_moved++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Out !== 16'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b Out=%h required 0 0 0000", bus.busy, bus.done, bus.Out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_one(input string name, input logic [15:0] x, input int n, input bit op);
    int lat, bc, ov, mv;
    logic [15:0] exp;
    exp = model(x, n, op);
    launch(x, n, op);
    wait_done(last_out, lat, bc, ov, mv);
    checks++;
    if (lat !== n + 1 || bus.Out !== exp) begin
      errors++;
      $display("FAIL %s: In=%h amt=%0d op=%0d Out=%h lat=%0d required Out=%h lat=%0d",
               name, x, n, op, bus.Out, lat, exp, n + 1);
    end
    checks++;
    if (bc !== n || ov !== 0 || mv !== 0) begin
      errors++;
      $display("FAIL %s_busy: busy_cycles=%0d overlap=%0d out_moved=%0d required %0d 0 0",
               name, bc, ov, mv, n);
    end
    last_out = exp;
  endtask

  task automatic test_directed();
    run_one("rol_8001_1", 16'h8001, 1, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Out !== 16'h0003 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL hold: Out=%h busy=%b done=%b required 0003 0 0", bus.Out, bus.busy, bus.done);
    end
    @(negedge clk);
    run_one("sll_8001_1", 16'h8001, 1, 1'b1);
    @(negedge clk);
    run_one("sll_f0f0_4", 16'hF0F0, 4, 1'b1);
    @(negedge clk);
    run_one("amt0_1234", 16'h1234, 0, 1'b0);
    @(negedge clk);
    run_one("rol_0001_15", 16'h0001, 15, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int lat, bc, ov, mv, extra;
    launch(16'h00FF, 8, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.In = 16'hAAAA; bus.ShAmt = 4'd1; bus.Op = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(last_out, lat, bc, ov, mv);
    checks++;
    if (bus.Out !== 16'hFF00 || lat !== 6) begin
      errors++;
      $display("FAIL ignore_busy: Out=%h lat=%0d required FF00 6", bus.Out, lat);
    end
    last_out = 16'hFF00;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.Out !== 16'hFF00) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_busy_extra: spurious events=%0d required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov, mv;
    launch(16'h1357, 3, 1'b0);
    wait_done(last_out, lat, bc, ov, mv);
    last_out = model(16'h1357, 3, 1'b0);
    launch(16'h0003, 2, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_idle: busy=%b required 1", bus.busy);
    end
    wait_done(last_out, lat, bc, ov, mv);
    checks++;
    if (bus.Out !== 16'h000C || lat !== 3) begin
      errors++;
      $display("FAIL b2b: Out=%h lat=%0d required 000C 3", bus.Out, lat);
    end
    last_out = 16'h000C;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int extra;
    launch(16'hBEEF, 10, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Out !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b Out=%h required 0 0 0000", bus.busy, bus.done, bus.Out);
    end
    @(negedge clk);
    rst = 1'b0;
    last_out = 16'h0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.Out !== 16'h0) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet: events=%0d required 0", extra);
    end
    run_one("post_reset_op", 16'hC0DE, 5, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc, ov, mv, n;
    bit op;
    logic [15:0] x, exp;
    for (int i = 0; i < 40; i++) begin
      x  = 16'($urandom);
      n  = int'($urandom_range(0, 15));
      op = 1'($urandom);
      exp = model(x, n, op);
      launch(x, n, op);
      wait_done(last_out, lat, bc, ov, mv);
      checks++;
      if (bus.Out !== exp || lat !== n + 1 || bc !== n || ov !== 0 || mv !== 0) begin
        errors++;
        $display("FAIL random[%0d]: In=%h amt=%0d op=%0d Out=%h lat=%0d busy=%0d ov=%0d mv=%0d required Out=%h lat=%0d busy=%0d",
                 i, x, n, op, bus.Out, lat, bc, ov, mv, exp, n + 1, n);
      end
      last_out = exp;
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.In    = '0;
    bus.ShAmt = '0;
    bus.Op    = 1'b0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotate_left_seq.md
Name: rotate_left_seq

Overview:
- Multi-cycle left rotator/shifter for the 16-bit datapath.
- It is the left-direction companion to the existing combinational rotate-right unit.
- It shifts one bit position per clock under a start/done handshake, so that the execute stage can issue rotate-left (ROL) and shift-left-logical (SLL) operations without a second full barrel network.
- It sits beside the ALU. Stall logic uses busy to hold the pipeline until done.

Parameters:
- WIDTH, 16: data width in bits.
- SHW, 4: shift-amount width. Must equal log2(WIDTH).

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request strobe. Sampled on the rising edge only while the block is accepting.
- In, input, WIDTH: operand. Captured when start is accepted.
- ShAmt, input, SHW: shift/rotate amount, 0..15. Captured when start is accepted.
- Op, input, 1: operation select. 0 = rotate left; 1 = shift left logical (zero fill). Captured when start is accepted.
- busy, output, 1: high while an operation is in progress (SHIFT state).
- done, output, 1: one-cycle pulse when Out holds a new result.
- Out, output, WIDTH: result register. Holds its value until the next completion.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, Out=0, internal data/count/op cleared. Applies immediately, including mid-operation. The operation in flight is discarded and produces no done pulse.
- States: IDLE, SHIFT, DONE.
  - busy=1 only in SHIFT.
  - done=1 only in DONE.
- Accepting: start is honoured in IDLE and in DONE, giving back-to-back issue. start is ignored in SHIFT, and In, ShAmt and Op changes have no effect there.
- Accept edge: data<=In, count<=ShAmt, op_r<=Op.
  - Next state is SHIFT if ShAmt!=0.
  - Otherwise next state is DONE, and Out<=In on the same edge.
- SHIFT, each edge:
  - op_r=0: data<={data[WIDTH-2:0], data[WIDTH-1]}.
  - op_r=1: data<={data[WIDTH-2:0], 1'b0}.
  - count<=count-1.
  - When count==1 on this edge, Out<=shifted value and the next state is DONE.
- DONE lasts exactly one cycle, with done=1.
  - start=1: accept as above. The next state is SHIFT or DONE per the new ShAmt.
  - start=0: the next state is IDLE.
- Latency: done is high in cycle k+ShAmt+1, where start was sampled on the edge ending cycle k.
  - ShAmt=0 gives 1 cycle; ShAmt=15 gives 16 cycles.
  - Throughput is one result per ShAmt+1 cycles.
- Out changes only on the edge entering DONE. It never shows intermediate shift values and stays stable through IDLE and SHIFT.
- Equivalence:
  - Op=0: Out = In rotated left by ShAmt (mod 16).
  - Op=1: Out = In<<ShAmt, with vacated LSBs zero.
- done and busy are never high together. No combinational path exists from any input to any output.

Test Plan:
- Reset, then start In=16'h8001, ShAmt=1, Op=0 -> busy for 1 cycle, then done pulse with Out=16'h0003; Out still 16'h0003 three cycles later.
- Start In=16'h8001, ShAmt=1, Op=1 -> Out=16'h0002. Then start In=16'hF0F0, ShAmt=4, Op=1 -> done 5 cycles after start, Out=16'h0F00.
- Start In=16'h1234, ShAmt=0 -> busy never high, done in the next cycle, Out=16'h1234. Then In=16'h0001, ShAmt=15, Op=0 -> done exactly 16 cycles after start, Out=16'h8000.
- Start In=16'h00FF, ShAmt=8, Op=0. Pulse start with In=16'hAAAA, ShAmt=1 while busy -> ignored; single done with Out=16'hFF00.
- Back-to-back: during the done cycle of the previous op, assert start with In=16'h0003, ShAmt=2, Op=0 -> no IDLE cycle between ops; next done 3 cycles later with Out=16'h000C.
- Start In=16'hBEEF, ShAmt=10, then assert rst asynchronously (between edges) after 4 cycles -> busy, done and Out go to 0 immediately; no done after release; a fresh op afterwards completes correctly.
